router_arbiter: RTL



---
 rtl/router_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/router_arbiter.sv
// Round-robin arbiter/sequencer owning the 4-to-4 router sender/receiver selects.
// Latency: grant one edge after a sampled request; release one edge after req[W] drops; all outputs registered.
// Backpressure: level-sensitive requests, denied requesters hold req and are re-arbitrated every IDLE cycle.
// Optional hold-limit timeout enabled by macro ROUTER_ARB_TIMEOUT_EN (uses MAX_HOLD).
module router_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] req,
  input  logic [7:0] dest,
  output logic [3:0] gnt,
  output logic [1:0] sender,
  output logic [1:0] receiver,
  output logic       bus_valid,
  output logic       timeout
);

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t     r_state;
  logic [1:0] r_ptr;
  logic [3:0] r_gnt;
  logic [1:0] r_sender;
  logic [1:0] r_receiver;
  logic       r_bus_valid;
  logic [1:0] w_win;
  logic       w_any;

  // Reject hold limits that the 8-bit counter cannot represent.
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("router_arbiter: MAX_HOLD must be in 1..255");
  end

  // First set request scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  function automatic logic [1:0] f_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    f_pick = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) f_pick = idx;
    end
  endfunction

  assign w_win = f_pick(req, r_ptr);
  assign w_any = |req;

`ifdef ROUTER_ARB_TIMEOUT_EN
  logic [7:0] r_hold;
  logic       r_timeout;

  // Arbitration FSM with hold counter; a grant reaching MAX_HOLD cycles is force-released.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_ptr       <= 2'd0;
      r_gnt       <= 4'd0;
      r_sender    <= 2'd0;
      r_receiver  <= 2'd0;
      r_bus_valid <= 1'b0;
      r_hold      <= 8'd0;
      r_timeout   <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_gnt       <= 4'b0001 << w_win;
            r_sender    <= w_win;
            r_receiver  <= dest[{w_win, 1'b0} +: 2];
            r_ptr       <= w_win + 2'd1;
            r_bus_valid <= 1'b1;
            r_hold      <= 8'd1;
            r_state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (!req[r_sender]) begin
            r_gnt       <= 4'd0;
            r_bus_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end else if (r_hold >= 8'(MAX_HOLD)) begin
            // Normal release above takes precedence, so timeout only fires while req[W] is still high.
            r_gnt       <= 4'd0;
            r_bus_valid <= 1'b0;
            r_timeout   <= 1'b1;
            r_state     <= ST_IDLE;
          end else begin
            r_hold <= r_hold + 8'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign timeout = r_timeout;
`else
  // Arbitration FSM; a grant is held until its requester drops req.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_ptr       <= 2'd0;
      r_gnt       <= 4'd0;
      r_sender    <= 2'd0;
      r_receiver  <= 2'd0;
      r_bus_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_gnt       <= 4'b0001 << w_win;
            r_sender    <= w_win;
            r_receiver  <= dest[{w_win, 1'b0} +: 2];
            r_ptr       <= w_win + 2'd1;
            r_bus_valid <= 1'b1;
            r_state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (!req[r_sender]) begin
            r_gnt       <= 4'd0;
            r_bus_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign timeout = 1'b0;
`endif

  assign gnt       = r_gnt;
  assign sender    = r_sender;
  assign receiver  = r_receiver;
  assign bus_valid = r_bus_valid;

endmodule
